// File: rtl/fpadder_feeder.sv
// rtl/fpadder_feeder.sv - serialises operand pairs onto the serial-operand fpadder and holds its result
module fpadder_feeder #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      fp_a,
  input  logic             fp_ready,
  input  logic [31:0]      fp_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_sum,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err,
  output logic             busy,
  output logic [CNT_W-1:0] job_count
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_BUSY
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        fp_a_q, fp_a_d;
  logic [31:0]        b_q, b_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               res_valid_q, res_valid_d;
  logic [31:0]        res_sum_q, res_sum_d;
  logic [TAG_W-1:0]   res_tag_q, res_tag_d;
  logic               res_err_q, res_err_d;
  logic [CNT_W-1:0]   job_count_q, job_count_d;
  logic               accept;

  // Accept only while the adder sits in its start state, so A lands exactly in its loada cycle
  assign in_ready  = (state_q == S_IDLE) & fp_ready & ~res_valid_q;
  assign accept    = in_valid & in_ready;

  assign fp_a      = fp_a_q;
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_tag   = res_tag_q;
  assign res_err   = res_err_q;
  assign busy      = (state_q != S_IDLE);
  assign job_count = job_count_q;

  // State and result registers; reset drops any in-flight job without producing a result
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      fp_a_q      <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      timer_q     <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_tag_q   <= '0;
      res_err_q   <= 1'b0;
      job_count_q <= '0;
    end else begin
      state_q     <= state_d;
      fp_a_q      <= fp_a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      timer_q     <= timer_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_tag_q   <= res_tag_d;
      res_err_q   <= res_err_d;
      job_count_q <= job_count_d;
    end
  end

  // Next-state: walk A then B onto the adder input in lock-step with its FSM, then wait for the sum
  always_comb begin
    state_d     = state_q;
    fp_a_d      = fp_a_q;
    b_d         = b_q;
    tag_d       = tag_q;
    timer_d     = timer_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_tag_d   = res_tag_q;
    res_err_d   = res_err_q;
    job_count_d = job_count_q;

    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          fp_a_d  = in_a;
          b_d     = in_b;
          tag_d   = in_tag;
          state_d = S_LOAD_A;
        end else begin
          // Idle adder keeps cycling on 0+0; those sums are never captured
          fp_a_d = '0;
        end
      end
      S_LOAD_A: begin
        fp_a_d  = b_q;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        fp_a_d  = '0;
        timer_d = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        timer_d = timer_q + TMR_W'(1);
        if (fp_ready) begin
          res_sum_d   = fp_sum;
          res_tag_d   = tag_q;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          job_count_d = job_count_q + CNT_W'(1);
          state_d     = S_IDLE;
        end else if (timer_q == TMR_LAST) begin
          res_sum_d   = '0;
          res_tag_d   = tag_q;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          job_count_d = job_count_q + CNT_W'(1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fpadder_feeder.sv
// tb/tb_fpadder_feeder.sv - randomized self-checking bench for fpadder_feeder with a behavioural adder stub
module tb_fpadder_feeder;

  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 8;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      fp_a;
  logic             fp_ready;
  logic [31:0]      fp_sum;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_sum;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;
  logic             busy;
  logic [CNT_W-1:0] job_count;

  int checks = 0;
  int errors = 0;
  int jobs_done = 0;

  fpadder_feeder #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .fp_a(fp_a), .fp_ready(fp_ready), .fp_sum(fp_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_tag(res_tag),
    .res_err(res_err), .busy(busy), .job_count(job_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic real sp2real(input logic [31:0] x);
    real m;
    int  e;
    if (x[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    m = m * (2.0 ** e);
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    int          e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Behavioural serial-operand adder: start -> loada -> loadb -> compute -> start
  localparam int AS_START = 0, AS_LA = 1, AS_LB = 2, AS_CMP = 3;
  int          ad_st;
  int          ad_cnt;
  logic [31:0] ad_a, ad_b, ad_sum;
  bit          stuck;

  always @(posedge clock) begin
    if (reset) begin
      ad_st  <= AS_START;
      ad_cnt <= 0;
      ad_a   <= 32'h0;
      ad_b   <= 32'h0;
      ad_sum <= 32'h0;
    end else begin
      case (ad_st)
        AS_START: ad_st <= AS_LA;
        AS_LA: begin
          ad_a  <= fp_a;
          ad_st <= AS_LB;
        end
        AS_LB: begin
          ad_b   <= fp_a;
          ad_sum <= real2sp(sp2real(ad_a) + sp2real(fp_a));
          ad_cnt <= (ad_a == 32'h0 || fp_a == 32'h0) ? 2 : 2 + int'($urandom_range(0, 3));
          ad_st  <= AS_CMP;
        end
        default: begin
          if (!(stuck && ad_b != 32'h0)) begin
            if (ad_cnt <= 1) ad_st <= AS_START;
            else ad_cnt <= ad_cnt - 1;
          end
        end
      endcase
    end
  end

  assign fp_ready = (ad_st == AS_START);
  assign fp_sum   = fp_ready ? ad_sum : 32'hx;

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t,
                      output bit ok);
    ok       = 1'b0;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        @(negedge clock);
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || res_sum !== 32'h0 || res_tag !== '0 ||
        res_err !== 1'b0 || job_count !== '0 || fp_a !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b res_valid=%b sum=%h tag=%h err=%b cnt=%0d fp_a=%h expected all zero",
               busy, res_valid, res_sum, res_tag, res_err, job_count, fp_a);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_add();
    bit ok;
    int n;
    res_ready = 1'b1;
    send(32'h3F800000, 32'h40000000, 4'd3, ok);
    wait_result(n);
    checks++;
    if (!ok || !res_valid) begin
      errors++;
      $display("FAIL basic_handshake: accepted=%b res_valid=%b expected 1 1", ok, res_valid);
    end
    checks++;
    if (res_sum !== 32'h40400000 || res_tag !== 4'd3 || res_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: sum=%h tag=%h err=%b expected 40400000 3 0", res_sum, res_tag, res_err);
    end
    jobs_done++;
  endtask

  task automatic test_latency();
    bit ok;
    int n;
    res_ready = 1'b1;
    @(negedge clock);
    send(32'h00000000, 32'h40A00000, 4'd6, ok);
    wait_result(n);
    checks++;
    if (!ok || n != 5) begin
      errors++;
      $display("FAIL zero_latency: accepted=%b cycles=%0d expected 5", ok, n);
    end
    checks++;
    if (res_sum !== 32'h40A00000 || res_tag !== 4'd6 || res_err !== 1'b0) begin
      errors++;
      $display("FAIL zero_result: sum=%h tag=%h err=%b expected 40a00000 6 0", res_sum, res_tag, res_err);
    end
    jobs_done++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    @(negedge clock);
    res_ready = 1'b0;
    send(32'h3F800000, 32'h40000000, 4'd5, ok);
    wait_result(n);
    checks++;
    if (!ok || res_sum !== 32'h40400000 || res_tag !== 4'd5) begin
      errors++;
      $display("FAIL hold_job1: accepted=%b sum=%h tag=%h expected 40400000 5", ok, res_sum, res_tag);
    end
    jobs_done++;
    in_a     = 32'h40800000;
    in_b     = 32'h3F800000;
    in_tag   = 4'd9;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checks++;
      if (in_ready !== 1'b0 || res_valid !== 1'b1 || res_sum !== 32'h40400000 ||
          res_tag !== 4'd5 || res_err !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable: cycle=%0d in_ready=%b res_valid=%b sum=%h tag=%h expected 0 1 40400000 5",
                 i, in_ready, res_valid, res_sum, res_tag);
      end
    end
    res_ready = 1'b1;
    send(32'h40800000, 32'h3F800000, 4'd9, ok);
    wait_result(n);
    checks++;
    if (!ok || !res_valid || res_sum !== 32'h40A00000 || res_tag !== 4'd9 || res_err !== 1'b0) begin
      errors++;
      $display("FAIL release_job2: accepted=%b valid=%b sum=%h tag=%h err=%b expected 1 1 40a00000 9 0",
               ok, res_valid, res_sum, res_tag, res_err);
    end
    jobs_done++;
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    @(negedge clock);
    res_ready = 1'b1;
    stuck     = 1'b1;
    send(32'h3F800000, 32'h40000000, 4'd7, ok);
    wait_result(n);
    checks++;
    if (!ok || n != TIMEOUT + 2) begin
      errors++;
      $display("FAIL timeout_latency: accepted=%b cycles=%0d expected %0d", ok, n, TIMEOUT + 2);
    end
    checks++;
    if (res_valid !== 1'b1 || res_err !== 1'b1 || res_sum !== 32'h0 || res_tag !== 4'd7) begin
      errors++;
      $display("FAIL timeout_result: valid=%b err=%b sum=%h tag=%h expected 1 1 00000000 7",
               res_valid, res_err, res_sum, res_tag);
    end
    jobs_done++;
    stuck = 1'b0;
    @(negedge clock);
    checks++;
    if (job_count !== CNT_W'(jobs_done) || busy !== 1'b0) begin
      errors++;
      $display("FAIL job_count_mid: got %0d busy=%b expected %0d busy=0", job_count, busy, jobs_done);
    end
  endtask

  task automatic test_reset_midjob();
    bit ok;
    int n;
    for (int i = 0; i < 30 && !fp_ready; i++) @(negedge clock);
    res_ready = 1'b1;
    send(32'h3F800000, 32'h40000000, 4'd4, ok);
    @(negedge clock);
    checks++;
    if (!ok || busy !== 1'b1) begin
      errors++;
      $display("FAIL midjob_busy: accepted=%b busy=%b expected 1 1", ok, busy);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || fp_a !== 32'h0 || job_count !== '0) begin
      errors++;
      $display("FAIL midjob_reset: busy=%b valid=%b fp_a=%h cnt=%0d expected 0 0 00000000 0",
               busy, res_valid, fp_a, job_count);
    end
    send(32'h40400000, 32'h3F800000, 4'd2, ok);
    wait_result(n);
    checks++;
    if (!ok || !res_valid || res_sum !== 32'h40800000 || res_tag !== 4'd2 || res_err !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_job: accepted=%b valid=%b sum=%h tag=%h err=%b expected 1 1 40800000 2 0",
               ok, res_valid, res_sum, res_tag, res_err);
    end
  endtask

  task automatic test_back_to_back();
    bit               ok;
    int               n;
    int               na, nb;
    logic [31:0]      exp_sum;
    logic [TAG_W-1:0] t;
    res_ready = 1'b1;
    apply_reset();
    for (int j = 0; j < 300; j++) begin
      na = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 2000)) - 1000;
      nb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 2000)) - 1000;
      t  = TAG_W'($urandom_range(0, 15));
      exp_sum = real2sp(real'(na + nb));
      send(real2sp(real'(na)), real2sp(real'(nb)), t, ok);
      wait_result(n);
      checks++;
      if (!ok || !res_valid || res_sum !== exp_sum || res_tag !== t || res_err !== 1'b0) begin
        errors++;
        $display("FAIL random_job %0d: %0d+%0d accepted=%b valid=%b sum=%h tag=%h err=%b expected sum=%h tag=%h err=0",
                 j, na, nb, ok, res_valid, res_sum, res_tag, res_err, exp_sum, t);
      end
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    @(negedge clock);
    checks++;
    if (job_count !== CNT_W'(300 % (1 << CNT_W))) begin
      errors++;
      $display("FAIL job_count_wrap: got %0d expected %0d", job_count, 300 % (1 << CNT_W));
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = 32'h0;
    in_b      = 32'h0;
    in_tag    = '0;
    res_ready = 1'b1;
    stuck     = 1'b0;
    test_reset();
    test_basic_add();
    test_latency();
    test_backpressure();
    test_timeout();
    test_reset_midjob();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
